// File: rtl/pacman_pkg.sv
// Shared Pac-Man constants: direction codes, tile grid and mover FSM states.
package pacman_pkg;

  localparam logic [2:0] DIR_RIGHT = 3'd0;
  localparam logic [2:0] DIR_LEFT  = 3'd2;
  localparam logic [2:0] DIR_DOWN  = 3'd3;
  localparam logic [2:0] DIR_UP    = 3'd4;

  localparam int GRID_TILE_LOG2 = 4;
  localparam int GRID_ORIGIN_X  = 7;
  localparam int GRID_ORIGIN_Y  = 2;

  typedef enum logic [1:0] {
    IDLE,
    Q_REQ,
    Q_CUR,
    STEP
  } mv_state_t;

  function automatic logic dir_is_x(input logic [2:0] d);
    return (d == DIR_RIGHT) || (d == DIR_LEFT);
  endfunction

  function automatic logic [2:0] dir_rev(input logic [2:0] d);
    logic [2:0] r;
    case (d)
      DIR_RIGHT: r = DIR_LEFT;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_DOWN:  r = DIR_UP;
      DIR_UP:    r = DIR_DOWN;
      default:   r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pacman_motion_debounce.sv
// Button conditioner: 2-flop synchroniser then a stability counter.
module btn_debounce #(
  parameter int DEB_BITS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  logic [1:0]          sync;
  logic [DEB_BITS-1:0] cnt;

  // level follows the synced input once it has differed for 2^DEB_BITS cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pacman_motion.sv
// Pac-Man mover: button direction request, wall-checked tile stepping,
// tunnel wrap and mouth animation feeding the sprite draw stage.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter int START_X    = 471,
  parameter int START_Y    = 386,
  parameter int ORIGIN_X   = GRID_ORIGIN_X,
  parameter int ORIGIN_Y   = GRID_ORIGIN_Y,
  parameter int TILE_LOG2  = GRID_TILE_LOG2,
  parameter int X_WRAP_MIN = 7,
  parameter int X_WRAP_MAX = 903,
  parameter int DEB_BITS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        move_tick,
  input  logic        anim_tick,
  output logic        wall_req,
  output logic [6:0]  wall_col,
  output logic [5:0]  wall_row,
  input  logic        wall_ack,
  input  logic        wall_hit,
  output logic [10:0] pacman_blkpos_x,
  output logic [9:0]  pacman_blkpos_y,
  output logic [3:0]  pacman_dir,
  output logic        moving
);

  logic deb_u, deb_d, deb_l, deb_r;

  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_u (
    .clk(clk), .rst(rst), .btn(btn_u), .level(deb_u)
  );
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_d (
    .clk(clk), .rst(rst), .btn(btn_d), .level(deb_d)
  );
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_l (
    .clk(clk), .rst(rst), .btn(btn_l), .level(deb_l)
  );
  btn_debounce #(.DEB_BITS(DEB_BITS)) u_deb_r (
    .clk(clk), .rst(rst), .btn(btn_r), .level(deb_r)
  );

  logic [2:0] req_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_dir <= DIR_RIGHT;
    end else if (deb_d) begin
      req_dir <= DIR_DOWN;
    end else if (deb_u) begin
      req_dir <= DIR_UP;
    end else if (deb_l) begin
      req_dir <= DIR_LEFT;
    end else if (deb_r) begin
      req_dir <= DIR_RIGHT;
    end
  end

  mv_state_t   state, state_n;
  logic [10:0] x, x_n;
  logic [9:0]  y, y_n;
  logic [2:0]  cur_dir, cur_n;
  logic        mov_n, req_n, frame;
  logic [6:0]  col_n;
  logic [5:0]  row_n;

  logic [10:0] dx;
  logic [9:0]  dy;
  logic        x_al, y_al, cur_al;
  logic [6:0]  t_col;
  logic [5:0]  t_row;
  logic [12:0] nb_req, nb_cur;

  function automatic logic [12:0] nbr(
    input logic [2:0] d,
    input logic [6:0] c,
    input logic [5:0] r
  );
    logic [6:0] nc;
    logic [5:0] nr;
    nc = c;
    nr = r;
    case (d)
      DIR_RIGHT: nc = c + 7'd1;
      DIR_LEFT:  nc = c - 7'd1;
      DIR_DOWN:  nr = r + 6'd1;
      DIR_UP:    nr = r - 6'd1;
      default:   nc = c;
    endcase
    return {nc, nr};
  endfunction

  assign dx     = x - 11'(ORIGIN_X);
  assign dy     = y - 10'(ORIGIN_Y);
  assign x_al   = (dx[TILE_LOG2-1:0] == '0);
  assign y_al   = (dy[TILE_LOG2-1:0] == '0);
  assign cur_al = dir_is_x(cur_dir) ? x_al : y_al;
  assign t_col  = 7'(dx >> TILE_LOG2);
  assign t_row  = 6'(dy >> TILE_LOG2);
  assign nb_req = nbr(req_dir, t_col, t_row);
  assign nb_cur = nbr(cur_dir, t_col, t_row);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      x        <= 11'(START_X);
      y        <= 10'(START_Y);
      cur_dir  <= DIR_RIGHT;
      moving   <= 1'b0;
      wall_req <= 1'b0;
      wall_col <= '0;
      wall_row <= '0;
    end else begin
      state    <= state_n;
      x        <= x_n;
      y        <= y_n;
      cur_dir  <= cur_n;
      moving   <= mov_n;
      wall_req <= req_n;
      wall_col <= col_n;
      wall_row <= row_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    cur_n   = cur_dir;
    mov_n   = moving;
    req_n   = wall_req;
    col_n   = wall_col;
    row_n   = wall_row;
    unique case (state)
      IDLE: begin
        if (move_tick) begin
          if (!cur_al) begin
            if (req_dir == dir_rev(cur_dir)) cur_n = req_dir;
            state_n = STEP;
          end else if (x_al && y_al) begin
            state_n = Q_REQ;
            req_n   = 1'b1;
            {col_n, row_n} = nb_req;
          end
        end
      end
      Q_REQ: begin
        if (wall_req && wall_ack) begin
          req_n = 1'b0;
          if (!wall_hit) begin
            cur_n   = req_dir;
            state_n = STEP;
          end else if (req_dir != cur_dir) begin
            state_n = Q_CUR;
          end else begin
            mov_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      Q_CUR: begin
        // request drops for one cycle between the two queries
        if (!wall_req) begin
          req_n = 1'b1;
          {col_n, row_n} = nb_cur;
        end else if (wall_ack) begin
          req_n = 1'b0;
          if (wall_hit) begin
            mov_n   = 1'b0;
            state_n = IDLE;
          end else begin
            state_n = STEP;
          end
        end
      end
      STEP: begin
        case (cur_dir)
          DIR_RIGHT:
            x_n = (x == 11'(X_WRAP_MAX)) ? 11'(X_WRAP_MIN) : x + 11'd1;
          DIR_LEFT:
            x_n = (x == 11'(X_WRAP_MIN)) ? 11'(X_WRAP_MAX) : x - 11'd1;
          DIR_DOWN: y_n = y + 10'd1;
          DIR_UP:   y_n = y - 10'd1;
          default:  x_n = x;
        endcase
        mov_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame <= 1'b0;
    end else if (anim_tick && moving) begin
      frame <= ~frame;
    end
  end

  assign pacman_blkpos_x = x;
  assign pacman_blkpos_y = y;
  assign pacman_dir      = {cur_dir, frame};

endmodule
